// File: rtl/lsu_mc_if.sv
// Core-side request/response and memory-side req/ack signals of the load/store unit.
// slave is the LSU view; master is the core plus memory view.
interface lsu_mc_if;
  logic        i_req;
  logic        i_wren;
  logic [2:0]  i_funct3;
  logic [31:0] i_addr;
  logic [31:0] i_st_data;
  logic        o_stall;
  logic        o_done;
  logic [31:0] o_ld_data;
  logic        o_misalign;
  logic        o_fault;
  logic        o_mem_req;
  logic        o_mem_we;
  logic [31:0] o_mem_addr;
  logic [3:0]  o_mem_bmask;
  logic [31:0] o_mem_wdata;
  logic        i_mem_ack;
  logic [31:0] i_mem_rdata;

  modport slave (
    input  i_req, i_wren, i_funct3, i_addr, i_st_data, i_mem_ack, i_mem_rdata,
    output o_stall, o_done, o_ld_data, o_misalign, o_fault,
           o_mem_req, o_mem_we, o_mem_addr, o_mem_bmask, o_mem_wdata
  );

  modport master (
    output i_req, i_wren, i_funct3, i_addr, i_st_data, i_mem_ack, i_mem_rdata,
    input  o_stall, o_done, o_ld_data, o_misalign, o_fault,
           o_mem_req, o_mem_we, o_mem_addr, o_mem_bmask, o_mem_wdata
  );
endinterface

// File: rtl/lsu_mc.sv
// Multi-cycle load/store unit: latches one request, runs a single req/ack bus cycle,
// aligns stores, extends loads, and reports misalign/fault with a one-cycle done pulse.
//
//   state  | meaning
//   IDLE   | waiting for i_req; flagged requests skip the bus
//   ACCESS | bus request held until ack or timeout
//   RESP   | done pulse with result and flags
module lsu_mc #(
  parameter int unsigned TIMEOUT = 255
) (
  input logic     i_clk,
  input logic     i_rst,
  lsu_mc_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);
  localparam bit TO_EN = (TIMEOUT != 0);

  state_t      state_q, state_d;
  logic        wren_q;
  logic [2:0]  f3_q;
  logic [31:0] addr_q;
  logic [31:0] data_q;
  logic [31:0] ld_q;
  logic        mis_q;
  logic        flt_q;
  logic [CW-1:0] cnt_q;

  logic        illegal_in;
  logic        mis_in;
  logic        timeout_hit;
  logic [31:0] ld_ext;
  logic [31:0] st_wdata;
  logic [3:0]  st_mask;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  // Classify the incoming request; alignment only matters once funct3 is legal.
  always_comb begin
    illegal_in = 1'b0;
    mis_in     = 1'b0;
    if (bus.i_wren)
      illegal_in = (bus.i_funct3 > 3'b010);
    else
      illegal_in = (bus.i_funct3 == 3'b011) || (bus.i_funct3 == 3'b110) ||
                   (bus.i_funct3 == 3'b111);
    if (!illegal_in) begin
      case (bus.i_funct3[1:0])
        2'b01:   mis_in = bus.i_addr[0];
        2'b10:   mis_in = |bus.i_addr[1:0];
        default: mis_in = 1'b0;
      endcase
    end
  end

  always_comb begin
    state_d     = state_q;
    timeout_hit = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.i_req)
          state_d = (illegal_in || mis_in) ? RESP : ACCESS;
      end
      ACCESS: begin
        if (bus.i_mem_ack) begin
          state_d = RESP;
        end else if (TO_EN && (cnt_q == '0)) begin
          state_d     = RESP;
          timeout_hit = 1'b1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ld_byte = bus.i_mem_rdata[7:0];
    case (addr_q[1:0])
      2'b01:   ld_byte = bus.i_mem_rdata[15:8];
      2'b10:   ld_byte = bus.i_mem_rdata[23:16];
      2'b11:   ld_byte = bus.i_mem_rdata[31:24];
      default: ld_byte = bus.i_mem_rdata[7:0];
    endcase
    ld_half = addr_q[1] ? bus.i_mem_rdata[31:16] : bus.i_mem_rdata[15:0];
    case (f3_q)
      3'b000:  ld_ext = {{24{ld_byte[7]}}, ld_byte};
      3'b100:  ld_ext = {24'd0, ld_byte};
      3'b001:  ld_ext = {{16{ld_half[15]}}, ld_half};
      3'b101:  ld_ext = {16'd0, ld_half};
      default: ld_ext = bus.i_mem_rdata;
    endcase
  end

  always_comb begin
    st_wdata = data_q;
    st_mask  = 4'b1111;
    if (wren_q) begin
      case (f3_q[1:0])
        2'b00: begin
          st_wdata = {4{data_q[7:0]}};
          st_mask  = 4'b0001 << addr_q[1:0];
        end
        2'b01: begin
          st_wdata = {2{data_q[15:0]}};
          st_mask  = addr_q[1] ? 4'b1100 : 4'b0011;
        end
        default: begin
          st_wdata = data_q;
          st_mask  = 4'b1111;
        end
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      wren_q  <= 1'b0;
      f3_q    <= 3'd0;
      addr_q  <= 32'd0;
      data_q  <= 32'd0;
      ld_q    <= 32'd0;
      mis_q   <= 1'b0;
      flt_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (bus.i_req) begin
            wren_q <= bus.i_wren;
            f3_q   <= bus.i_funct3;
            addr_q <= bus.i_addr;
            data_q <= bus.i_st_data;
            mis_q  <= mis_in;
            flt_q  <= illegal_in;
            cnt_q  <= CNT_LOAD;
          end
        end
        ACCESS: begin
          if (bus.i_mem_ack)
            ld_q <= ld_ext;
          else if (timeout_hit)
            flt_q <= 1'b1;
          else if (cnt_q != '0)
            cnt_q <= cnt_q - 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Bus outputs are forced low outside ACCESS so flagged requests never reach memory.
  always_comb begin
    bus.o_stall     = ((state_q == IDLE) && bus.i_req) || (state_q == ACCESS);
    bus.o_mem_req   = (state_q == ACCESS);
    bus.o_mem_we    = (state_q == ACCESS) && wren_q;
    bus.o_mem_addr  = (state_q == ACCESS) ? {addr_q[31:2], 2'b00} : 32'd0;
    bus.o_mem_bmask = (state_q == ACCESS) ? st_mask : 4'b0000;
    bus.o_mem_wdata = ((state_q == ACCESS) && wren_q) ? st_wdata : 32'd0;
    bus.o_done      = (state_q == RESP);
    bus.o_misalign  = (state_q == RESP) && mis_q;
    bus.o_fault     = (state_q == RESP) && flt_q;
    bus.o_ld_data   = ((state_q == RESP) && !wren_q && !mis_q && !flt_q) ? ld_q : 32'd0;
  end

endmodule
